// File: rtl/mul_wb_scheduler.sv
// Multiply issue/writeback controller: RAW/WAW scoreboard, capacity stall, and an in-order
// skid FIFO sharing the register-file write port. `MUL_WB_BYPASS_EN enables the empty-FIFO bypass.
module mul_wb_scheduler #(
  parameter int NUM_REGS   = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MUL_STAGES = 5,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        dec_valid_i,
  input  logic                        dec_mul_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rd_id_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_ra_id_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rb_id_i,
  input  logic                        dec_ra_used_i,
  input  logic                        dec_rb_used_i,
  output logic                        issue_stall_o,
  output logic                        writeback_mul_o,
  input  logic                        mul_out_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] mul_out_rd_i,
  input  logic [REG_WIDTH-1:0]        mul_out_data_i,
  input  logic                        main_wb_valid_i,
  output logic                        mul_wb_valid_o,
  output logic [$clog2(NUM_REGS)-1:0] mul_wb_rd_o,
  output logic [REG_WIDTH-1:0]        mul_wb_data_o,
  output logic [NUM_REGS-1:0]         busy_regs_o,
  output logic                        overflow_err_o
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || MUL_STAGES < 1) begin : g_cfg_check
    $error("mul_wb_scheduler: BUF_DEPTH must be a power of two >= 2 and MUL_STAGES >= 1");
  end

  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CW-1:0]        inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                 ovf_q, ovf_d;
  logic [RW-1:0]        fifo_rd_q   [BUF_DEPTH];
  logic [REG_WIDTH-1:0] fifo_data_q [BUF_DEPTH];

  logic          hz, cap, fifo_empty, fifo_full, bypass, push, push_ok, pop;
  logic [CW:0]   occ;

  // Register 0 is never set busy, so it can never raise a hazard.
  assign hz  = (dec_ra_used_i & busy_q[dec_ra_id_i]) |
               (dec_rb_used_i & busy_q[dec_rb_id_i]) |
               (dec_mul_i     & busy_q[dec_rd_id_i]);
  assign occ = {1'b0, inflight_q} + {1'b0, count_q};
  assign cap = dec_mul_i & (occ >= (CW+1)'(BUF_DEPTH));

  assign issue_stall_o   = dec_valid_i & (hz | cap);
  assign writeback_mul_o = dec_valid_i & dec_mul_i & ~issue_stall_o;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(BUF_DEPTH));
  assign pop        = ~main_wb_valid_i & ~fifo_empty;

`ifdef MUL_WB_BYPASS_EN
  assign bypass = ~main_wb_valid_i & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push    = mul_out_valid_i & ~bypass;
  assign push_ok = push & (~fifo_full | pop);

  always_comb begin
    mul_wb_valid_o = pop;
    mul_wb_rd_o    = pop ? fifo_rd_q[rd_ptr_q]   : '0;
    mul_wb_data_o  = pop ? fifo_data_q[rd_ptr_q] : '0;
`ifdef MUL_WB_BYPASS_EN
    if (bypass & mul_out_valid_i) begin
      mul_wb_valid_o = 1'b1;
      mul_wb_rd_o    = mul_out_rd_i;
      mul_wb_data_o  = mul_out_data_i;
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    // Retire clears first so a same-cycle issue to that register wins.
    if (mul_wb_valid_o) busy_d[mul_wb_rd_o] = 1'b0;
    if (writeback_mul_o && dec_rd_id_i != '0) busy_d[dec_rd_id_i] = 1'b1;
    inflight_d = inflight_q + CW'(writeback_mul_o) - CW'(mul_out_valid_i);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    ovf_d      = ovf_q | (push & ~push_ok);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_rd_q[wr_ptr_q]   <= mul_out_rd_i;
      fifo_data_q[wr_ptr_q] <= mul_out_data_i;
    end
  end

  assign busy_regs_o    = busy_q;
  assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Bench for mul_wb_scheduler: queue-based reference model plus an ideal fixed-latency multiplier.
module tb_mul_wb_scheduler;
  localparam int NR = 32, RW = 5, W = 32, MS = 5, BD = 4;
`ifdef MUL_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_mul, dec_ra_used, dec_rb_used;
  logic [RW-1:0] dec_rd_id, dec_ra_id, dec_rb_id;
  logic issue_stall, writeback_mul;
  logic mul_out_valid;
  logic [RW-1:0] mul_out_rd;
  logic [W-1:0]  mul_out_data;
  logic main_wb_valid, mul_wb_valid;
  logic [RW-1:0] mul_wb_rd;
  logic [W-1:0]  mul_wb_data;
  logic [NR-1:0] busy_regs;
  logic overflow_err;

  always #5 clk = ~clk;

  mul_wb_scheduler #(.NUM_REGS(NR), .REG_WIDTH(W), .MUL_STAGES(MS), .BUF_DEPTH(BD)) dut (
    .clk_i(clk), .reset_i(reset),
    .dec_valid_i(dec_valid), .dec_mul_i(dec_mul),
    .dec_rd_id_i(dec_rd_id), .dec_ra_id_i(dec_ra_id), .dec_rb_id_i(dec_rb_id),
    .dec_ra_used_i(dec_ra_used), .dec_rb_used_i(dec_rb_used),
    .issue_stall_o(issue_stall), .writeback_mul_o(writeback_mul),
    .mul_out_valid_i(mul_out_valid), .mul_out_rd_i(mul_out_rd), .mul_out_data_i(mul_out_data),
    .main_wb_valid_i(main_wb_valid),
    .mul_wb_valid_o(mul_wb_valid), .mul_wb_rd_o(mul_wb_rd), .mul_wb_data_o(mul_wb_data),
    .busy_regs_o(busy_regs), .overflow_err_o(overflow_err)
  );

  typedef struct { logic [RW-1:0] rd; logic [W-1:0] data; } res_t;
  typedef struct { int due; logic [RW-1:0] rd; logic [W-1:0] data; } pend_t;

  res_t          m_fifo[$];
  pend_t         m_pipe[$];
  logic [NR-1:0] m_busy;
  int            m_inflight;
  bit            m_ovf, m_iss;
  int            cyc, n_chk, n_pass;
  int            wb_cyc[NR];
  int            iss_cyc;
  bit            iss_seen;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // One clock cycle: feed the multiplier output, compare, then advance the model.
  task automatic step();
    bit hz, cap, e_stall, e_wbm, e_wbv, do_pop, do_push;
    res_t e_wb;
    mul_out_valid = 1'b0; mul_out_rd = '0; mul_out_data = '0;
    if (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
      mul_out_valid = 1'b1; mul_out_rd = m_pipe[0].rd; mul_out_data = m_pipe[0].data;
      void'(m_pipe.pop_front());
    end
    #2;
    hz = (dec_ra_used && m_busy[dec_ra_id]) || (dec_rb_used && m_busy[dec_rb_id]) ||
         (dec_mul && m_busy[dec_rd_id]);
    cap = dec_mul && (m_inflight + m_fifo.size() >= BD);
    e_stall = dec_valid && (hz || cap);
    e_wbm = dec_valid && dec_mul && !e_stall;
    e_wbv = 0; e_wb.rd = '0; e_wb.data = '0; do_pop = 0; do_push = 0;
    if (main_wb_valid) do_push = mul_out_valid;
    else if (m_fifo.size() > 0) begin
      e_wbv = 1; e_wb = m_fifo[0]; do_pop = 1; do_push = mul_out_valid;
    end else if (BYP) begin
      e_wbv = mul_out_valid; e_wb.rd = mul_out_rd; e_wb.data = mul_out_data;
    end else do_push = mul_out_valid;

    chk("issue_stall", issue_stall, e_stall);
    chk("writeback_mul", writeback_mul, e_wbm);
    chk("mul_wb_valid", mul_wb_valid, e_wbv);
    if (e_wbv) chk("mul_wb_rd_data", {mul_wb_rd, mul_wb_data}, {e_wb.rd, e_wb.data});
    chk("busy_regs", busy_regs, m_busy);
    chk("overflow_err", overflow_err, m_ovf);

    if (mul_wb_valid === 1'b1 && !$isunknown(mul_wb_rd)) wb_cyc[mul_wb_rd] = cyc;
    if (dec_valid && issue_stall === 1'b0 && !iss_seen) begin iss_seen = 1; iss_cyc = cyc; end
    m_iss = dec_valid && !e_stall;

    if (reset) begin
      m_busy = '0; m_inflight = 0; m_fifo.delete(); m_pipe.delete(); m_ovf = 0;
    end else begin
      if (e_wbv) m_busy[e_wb.rd] = 1'b0;
      if (e_wbm && dec_rd_id != '0) m_busy[dec_rd_id] = 1'b1;
      m_inflight += int'(e_wbm) - int'(mul_out_valid);
      if (do_pop) void'(m_fifo.pop_front());
      if (do_push) begin
        if (m_fifo.size() < BD) m_fifo.push_back('{mul_out_rd, mul_out_data});
        else m_ovf = 1;
      end
      if (e_wbm) m_pipe.push_back('{cyc + MS, dec_rd_id, $urandom()});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(int n);
    dec_valid = 0; dec_mul = 0; dec_ra_used = 0; dec_rb_used = 0;
    repeat (n) step();
  endtask

  // Hold one instruction at decode until it issues; t is the cycle the DUT accepted it.
  task automatic issue(bit mul, logic [RW-1:0] rd, logic [RW-1:0] ra, logic [RW-1:0] rb,
                       bit rau, bit rbu, output int t);
    int n = 0;
    dec_valid = 1; dec_mul = mul; dec_rd_id = rd; dec_ra_id = ra; dec_rb_id = rb;
    dec_ra_used = rau; dec_rb_used = rbu;
    iss_seen = 0;
    do begin step(); n++; end while (!m_iss && n < 40);
    chk("issued_within_bound", {63'd0, iss_seen}, 64'd1);
    t = iss_seen ? iss_cyc : -1;
    dec_valid = 0; dec_mul = 0; dec_ra_used = 0; dec_rb_used = 0;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5;
    reset = 1; dec_valid = 0; dec_mul = 0; dec_ra_used = 0; dec_rb_used = 0;
    dec_rd_id = '0; dec_ra_id = '0; dec_rb_id = '0; main_wb_valid = 0;
    mul_out_valid = 0; mul_out_rd = '0; mul_out_data = '0;
    m_busy = '0; m_inflight = 0; m_ovf = 0; m_iss = 0;
    cyc = 0; n_chk = 0; n_pass = 0;
    foreach (wb_cyc[i]) wb_cyc[i] = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_regs, 64'd0);
    chk("rst_stall", issue_stall, 64'd0);
    chk("rst_wb_valid", mul_wb_valid, 64'd0);
    chk("rst_overflow", overflow_err, 64'd0);
    reset = 0;

    // RAW: MUL r3 then a reader of r3
    issue(1, 5'd3, 5'd0, 5'd0, 0, 0, t0);
    issue(0, 5'd0, 5'd3, 5'd0, 1, 0, t1);
    chk("raw_wb_cycle", wb_cyc[3] - t0, BYP ? 5 : 6);
    chk("raw_issue_delay", t1 - t0, BYP ? 6 : 7);
    idle(10);

    // WAW: back-to-back MUL r4
    issue(1, 5'd4, 5'd0, 5'd0, 0, 0, t0);
    issue(1, 5'd4, 5'd0, 5'd0, 0, 0, t1);
    chk("waw_issue_delay", t1 - t0, BYP ? 6 : 7);
    idle(10);

    // Capacity: five independent MULs
    issue(1, 5'd1, 5'd0, 5'd0, 0, 0, t1);
    issue(1, 5'd2, 5'd0, 5'd0, 0, 0, t2);
    issue(1, 5'd3, 5'd0, 5'd0, 0, 0, t3);
    issue(1, 5'd4, 5'd0, 5'd0, 0, 0, t4);
    issue(1, 5'd5, 5'd0, 5'd0, 0, 0, t5);
    chk("cap_fourth", t4 - t1, 3);
    chk("cap_fifth", t5 - t1, BYP ? 6 : 7);
    idle(14);

    // Main pipeline owns the port while r1..r3 arrive
    foreach (wb_cyc[i]) wb_cyc[i] = -1;
    issue(1, 5'd1, 5'd0, 5'd0, 0, 0, t0);
    issue(1, 5'd2, 5'd0, 5'd0, 0, 0, t1);
    issue(1, 5'd3, 5'd0, 5'd0, 0, 0, t2);
    while (cyc < t0 + 5 && cyc < 2000) step();
    main_wb_valid = 1;
    repeat (3) step();
    main_wb_valid = 0;
    idle(6);
    chk("queued_r1", wb_cyc[1] - t0, 8);
    chk("queued_r2", wb_cyc[2] - t0, 9);
    chk("queued_r3", wb_cyc[3] - t0, 10);
    chk("queued_overflow", overflow_err, 64'd0);
    idle(4);

    // Reset with one result queued and two in flight
    issue(1, 5'd1, 5'd0, 5'd0, 0, 0, t0);
    issue(1, 5'd2, 5'd0, 5'd0, 0, 0, t1);
    issue(1, 5'd3, 5'd0, 5'd0, 0, 0, t2);
    while (cyc < t0 + 5 && cyc < 2000) step();
    main_wb_valid = 1;
    step();
    reset = 1;
    step();
    reset = 0; main_wb_valid = 0;
    dec_valid = 1; dec_mul = 1; dec_rd_id = 5'd1; dec_ra_id = 5'd2; dec_rb_id = 5'd3;
    dec_ra_used = 1; dec_rb_used = 1;
    #1;
    chk("midrst_busy", busy_regs, 64'd0);
    chk("midrst_stall", issue_stall, 64'd0);
    chk("midrst_wb_valid", mul_wb_valid, 64'd0);
    issue(1, 5'd1, 5'd2, 5'd3, 1, 1, t3);
    idle(10);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if (!dec_valid || m_iss) begin
        dec_valid = ($urandom_range(0, 4) != 0);
        dec_mul = 1'($urandom_range(0, 1));
        dec_rd_id = RW'($urandom_range(0, 7));
        dec_ra_id = RW'($urandom_range(0, 7));
        dec_rb_id = RW'($urandom_range(0, 7));
        dec_ra_used = 1'($urandom_range(0, 1));
        dec_rb_used = 1'($urandom_range(0, 1));
      end
      main_wb_valid = ($urandom_range(0, 2) == 0);
      step();
    end
    main_wb_valid = 0;
    idle(16);
    chk("final_busy", busy_regs, 64'd0);
    chk("final_overflow", overflow_err, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
